fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 stall  input  1  hold PC and IF/ID register this cycle.
REQ-005 branch_taken  input  1  redirect PC and flush IF/ID this cycle.
REQ-006 branch_target  input  16  word address of the redirect target.
REQ-007 halt  input  1  stop fetching permanently until reset.
REQ-008 pc_out  output  16  current PC, driven to the instruction memory address.
REQ-009 instr_in  input  16  instruction word returned combinationally by the instruction memory for pc_out.
REQ-010 ifid_instr  output  16  registered instruction for decode.
REQ-011 ifid_pc  output  16  registered PC of ifid_instr.
REQ-012 ifid_valid  output  1  ifid_instr holds a real fetched instruction.
REQ-013 halted  output  1  block is in HALT state.

Function
REQ-014 The block SHALL implement the states BOOT, RUN and HALT.
REQ-015 pc_out SHALL be driven directly from the PC register, with no combinational path from any input.
REQ-016 In BOOT, the block SHALL hold the PC, keep ifid_valid=0, and move to RUN on the next edge; inputs are ignored in BOOT.
REQ-017 In RUN, input priority per cycle SHALL be halt > branch_taken > stall > normal.
REQ-018 Normal (RUN, no other input active): PC <= PC+1 (word addressing, modulo 2^16, so 16'hFFFF wraps to 16'h0000); ifid_instr <= instr_in; ifid_pc <= PC; ifid_valid <= 1.
REQ-019 branch_taken in RUN: PC <= branch_target; ifid_instr <= 16'h0000; ifid_valid <= 0; this applies even if stall=1.
REQ-020 stall in RUN without branch_taken or halt: PC, ifid_instr, ifid_pc and ifid_valid SHALL all hold their values.
REQ-021 halt in RUN: go to HALT; PC holds; ifid_valid <= 0; ifid_instr <= 16'h0000.
REQ-022 In HALT, the block SHALL hold all registers and ignore every input except rst; halted=1 only in HALT.
REQ-023 Fetch-to-decode latency SHALL be exactly one cycle: the instruction at address A appears on ifid_instr on the edge after pc_out=A is sampled.
REQ-024 ifid_pc SHALL equal the address from which ifid_instr was fetched whenever ifid_valid=1.

Reset
REQ-025 While rst=1, the block SHALL immediately and asynchronously force: state=BOOT; PC=RESET_PC; ifid_instr=16'h0000; ifid_pc=16'h0000; ifid_valid=0; halted=0.
REQ-026 Reset asserted mid-operation, including during stall or HALT, SHALL discard all state; no partial fetch survives.
REQ-027 The fetch counter (when compiled in) SHALL reset to 0.

Configuration
REQ-028 Macro FETCH_UNIT_FETCH_CNT_EN: when defined, the block SHALL add output fetch_count [31:0], incremented (wrapping) on each edge where a normal fetch per REQ-018 occurs.
REQ-029 When FETCH_UNIT_FETCH_CNT_EN is undefined, fetch_count and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Release reset with RESET_PC=0 and memory word[n]=16'h1000+n -> edge 1 BOOT, ifid_valid=0; edge 2 ifid_instr=16'h1000, ifid_pc=0; edge 3 ifid_instr=16'h1001, pc_out=2.
REQ-031 At pc_out=5 assert branch_taken with branch_target=16'h0040 and stall=1 for one cycle -> next edge pc_out=16'h0040, ifid_valid=0; following edge ifid_instr=word[0x40], ifid_pc=16'h0040.
REQ-032 At pc_out=7 assert stall for 3 cycles -> pc_out stays 7 and ifid_* stay unchanged for 3 edges; first edge after release ifid_pc=7.
REQ-033 Set RESET_PC=16'hFFFF and run 2 normal fetches -> ifid_pc=16'hFFFF then 16'h0000; pc_out wraps 16'hFFFF -> 0 -> 1.
REQ-034 Assert halt together with branch_taken at pc_out=3 -> HALT, halted=1, pc_out=3, ifid_valid=0; later toggling of branch_taken or stall changes nothing; asynchronous rst pulse -> pc_out=RESET_PC immediately, halted=0.
REQ-035 With FETCH_UNIT_FETCH_CNT_EN defined, run 10 fetches including 2 stall cycles and 1 branch -> fetch_count=7; with the macro undefined, the bench compiles without the fetch_count port.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: BOOT/RUN/HALT instruction fetch stage feeding an IF/ID register.
// Define FETCH_UNIT_FETCH_CNT_EN to add the fetch_count output.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        halt,
  output logic [15:0] pc_out,
  input  logic [15:0] instr_in,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc,
  output logic        ifid_valid,
  output logic        halted
`ifdef FETCH_UNIT_FETCH_CNT_EN
  , output logic [31:0] fetch_count
`endif
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, instr_q, instr_d, ipc_q, ipc_d;
  logic        valid_q, valid_d, fetch;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    fetch   = 1'b0;
    if (state_q == BOOT) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (halt) begin
        state_d = HALT;
        instr_d = 16'h0000;
        valid_d = 1'b0;
      end else if (branch_taken) begin
        pc_d    = branch_target;
        instr_d = 16'h0000;
        valid_d = 1'b0;
      end else if (!stall) begin
        fetch   = 1'b1;
        pc_d    = pc_q + 16'd1;
        instr_d = instr_in;
        ipc_d   = pc_q;
        valid_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
      ipc_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end
  assign pc_out     = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc    = ipc_q;
  assign ifid_valid = valid_q;
  assign halted     = (state_q == HALT);
`ifdef FETCH_UNIT_FETCH_CNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 32'd0;
    else if (fetch) cnt_q <= cnt_q + 32'd1;
  end
  assign fetch_count = cnt_q;
`else
  logic unused_fetch;
  assign unused_fetch = fetch;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit against a cycle-level reference model.
module tb_fetch_unit;
  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, branch_taken = 1'b0, halt = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] pc_out, instr_in, ifid_instr, ifid_pc;
  logic        ifid_valid, halted;
  logic [15:0] pc2, instr2, ii2, ipc2;
  logic        iv2, h2;
`ifdef FETCH_UNIT_FETCH_CNT_EN
  logic [31:0] fetch_count, fc2;
`endif
  always #5 clk = ~clk;
  assign instr_in = 16'h1000 + pc_out;
  assign instr2   = 16'h1000 + pc2;

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt(halt), .pc_out(pc_out), .instr_in(instr_in),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid), .halted(halted)
`ifdef FETCH_UNIT_FETCH_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(16'h0000), .halt(1'b0), .pc_out(pc2), .instr_in(instr2),
    .ifid_instr(ii2), .ifid_pc(ipc2), .ifid_valid(iv2), .halted(h2)
`ifdef FETCH_UNIT_FETCH_CNT_EN
    , .fetch_count(fc2)
`endif
  );

  typedef struct {
    logic [15:0] pc, ii, ipc;
    logic        iv, hl;
    logic [31:0] cnt;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;

  int          m_st;
  logic [15:0] m_pc, m_ii, m_ipc;
  logic        m_iv;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 16'h0000; m_ii = 16'h0000; m_ipc = 16'h0000; m_iv = 1'b0; m_cnt = 32'd0;
  endtask

  // Drive one cycle's inputs at a falling edge and queue the state expected after the next rising edge.
  task automatic step(input bit s, input bit b, input bit h, input logic [15:0] t);
    exp_t e;
    stall = s; branch_taken = b; halt = h; branch_target = t;
    if (m_st == 0) m_st = 1;
    else if (m_st == 1) begin
      if (h) begin m_st = 2; m_ii = 16'h0000; m_iv = 1'b0; end
      else if (b) begin m_pc = t; m_ii = 16'h0000; m_iv = 1'b0; end
      else if (!s) begin
        m_ii = 16'h1000 + m_pc; m_ipc = m_pc; m_iv = 1'b1; m_pc = m_pc + 16'd1; m_cnt = m_cnt + 1;
      end
    end
    e.pc = m_pc; e.ii = m_ii; e.ipc = m_ipc; e.iv = m_iv; e.hl = (m_st == 2); e.cnt = m_cnt;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_halted", halted, 1'b0);
    chk("rst_valid", ifid_valid, 1'b0);
    chk("rst_instr", ifid_instr, 16'h0000);
    chk("rst_ifid_pc", ifid_pc, 16'h0000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc_out", pc_out, e.pc);
      chk("ifid_instr", ifid_instr, e.ii);
      chk("ifid_valid", ifid_valid, e.iv);
      chk("halted", halted, e.hl);
      if (e.iv) chk("ifid_pc", ifid_pc, e.ipc);
`ifdef FETCH_UNIT_FETCH_CNT_EN
      chk("fetch_count", fetch_count, e.cnt);
`endif
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("init_pc", pc_out, 16'h0000);
    chk("init_valid", ifid_valid, 1'b0);
    chk("init_wrap_pc", pc2, 16'hFFFF);
    rst = 1'b0;
    model_reset();
    step(0, 0, 0, 16'h0);
    chk("boot_valid", ifid_valid, 1'b0);
    chk("wrap1_pc", pc2, 16'hFFFF);
    step(0, 0, 0, 16'h0);
    chk("r030_instr0", ifid_instr, 16'h1000);
    chk("wrap2_ifid_pc", ipc2, 16'hFFFF);
    chk("wrap2_pc", pc2, 16'h0000);
    step(0, 0, 0, 16'h0);
    chk("r030_instr1", ifid_instr, 16'h1001);
    chk("r030_pc2", pc_out, 16'h0002);
    chk("wrap3_ifid_pc", ipc2, 16'h0000);
    chk("wrap3_pc", pc2, 16'h0001);
    repeat (3) step(0, 0, 0, 16'h0);
    chk("at_pc5", pc_out, 16'h0005);
    step(1, 1, 0, 16'h0040);
    chk("br_pc", pc_out, 16'h0040);
    chk("br_valid", ifid_valid, 1'b0);
    step(0, 0, 0, 16'h0);
    chk("br_instr", ifid_instr, 16'h1040);
    chk("br_ifid_pc", ifid_pc, 16'h0040);
    do_reset();
    repeat (4) step(0, 0, 0, 16'h0);
    step(0, 1, 1, 16'h0099);
    chk("halt_flag", halted, 1'b1);
    chk("halt_pc", pc_out, 16'h0003);
    repeat (6) step($urandom_range(0, 1), $urandom_range(0, 1), 0, 16'($urandom));
    chk("halt_hold_pc", pc_out, 16'h0003);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 39) == 0, 16'($urandom));
    end
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
